rs_age: RTL and testbench

- Parametrised successor reservation station for the integer/branch path: RS_DEPTH entries, NUM_CDB wakeup broadcast channels, oldest-ready-first selection using an age matrix.
- Sits between the decoder (dispatch) and one external ALU (issue via valid/ready handshake), and snoops every CDB channel (ALU, LSB, ...).
- Flushed by the ROB's `clear` on mispredict.

---
 rtl/rs_pkg.sv | 33 +++
 rtl/rs_age_select.sv | 37 +++
 rtl/rs_age.sv | 233 +++++++++++++++++++++++
 tb/tb_rs_age.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults, op-type field layout and the per-entry control record for reservation stations.
package rs_pkg;

    localparam int unsigned RS_DEPTH_DEF  = 8;
    localparam int unsigned ROB_WIDTH_DEF = 4;
    localparam int unsigned NUM_CDB_DEF   = 2;
    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned ADDR_W        = 32;

    // Op-type layout: [4] branch, [3] inst[30] alternate, [2:0] funct3
    localparam int unsigned OP_W       = 5;
    localparam int unsigned OP_BR_BIT  = 4;
    localparam int unsigned OP_ALT_BIT = 3;
    localparam int unsigned OP_F3_LSB  = 0;
    localparam int unsigned OP_F3_W    = 3;

    typedef logic [OP_W-1:0] op_t;

    // Width-fixed part of an entry; operand values and tags live in parameterised arrays
    typedef struct packed {
        logic              busy;
        logic              dj;
        logic              dk;
        op_t               op;
        logic [ADDR_W-1:0] tja;
        logic [ADDR_W-1:0] fja;
    } rs_ctl_t;

    function automatic logic op_is_branch(input op_t op);
        return op[OP_BR_BIT];
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: combinational oldest-ready picker over an age matrix (older[i][j]=1: i older than j).
module rs_age_select #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]        ready,
    input  logic [N-1:0][N-1:0] older,
    output logic [N-1:0]        grant,
    output logic [IW-1:0]       idx,
    output logic                valid
);

    logic [N-1:0] blocked;

    // An entry is blocked when any ready entry is older than it
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                blocked[i] = blocked[i] | (ready[j] & older[j][i]);
            end
        end
    end

    // One-hot grant, its index, and the any-grant flag
    always_comb begin
        grant = ready & ~blocked;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = IW'(i);
            end
        end
        valid = |grant;
    end

endmodule

// File: rtl/rs_age.sv
// rs_age: integer/branch reservation station with CDB wakeup and oldest-ready-first issue.
// Optional macro RS_ISSUE_BYPASS_EN: offers a fully resolved dispatch on iss_* in the same cycle
// when no stored entry is ready.
module rs_age
    import rs_pkg::*;
#(
    parameter int unsigned RS_DEPTH  = RS_DEPTH_DEF,
    parameter int unsigned RS_WIDTH  = $clog2(RS_DEPTH),
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int unsigned NUM_CDB   = NUM_CDB_DEF,
    parameter int unsigned XLEN      = XLEN_DEF
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic                         dec_valid,
    input  logic [OP_W-1:0]              dec_type,
    input  logic [XLEN-1:0]              val_j,
    input  logic [XLEN-1:0]              val_k,
    input  logic                         has_dep_j,
    input  logic                         has_dep_k,
    input  logic [ROB_WIDTH-1:0]         dep_j,
    input  logic [ROB_WIDTH-1:0]         dep_k,
    input  logic [ROB_WIDTH-1:0]         rob_id,
    input  logic [ADDR_W-1:0]            tja,
    input  logic [ADDR_W-1:0]            fja,
    output logic                         rs_full,
    output logic [RS_WIDTH:0]            rs_count,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [OP_W-1:0]              iss_op,
    output logic [XLEN-1:0]              iss_lhs,
    output logic [XLEN-1:0]              iss_rhs,
    output logic [ROB_WIDTH-1:0]         iss_rob_id,
    output logic [ADDR_W-1:0]            iss_tja,
    output logic [ADDR_W-1:0]            iss_fja
);

    localparam int unsigned CW = RS_WIDTH + 1;

    rs_ctl_t                    ctl   [RS_DEPTH];
    logic [XLEN-1:0]            vj    [RS_DEPTH];
    logic [XLEN-1:0]            vk    [RS_DEPTH];
    logic [ROB_WIDTH-1:0]       qj    [RS_DEPTH];
    logic [ROB_WIDTH-1:0]       qk    [RS_DEPTH];
    logic [ROB_WIDTH-1:0]       rob   [RS_DEPTH];
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older;

    logic [RS_DEPTH-1:0]        busy;
    logic [RS_DEPTH-1:0]        ready;
    logic [RS_DEPTH-1:0]        grant;
    logic [RS_DEPTH-1:0]        wake_j;
    logic [RS_DEPTH-1:0]        wake_k;
    logic [XLEN-1:0]            wake_j_val [RS_DEPTH];
    logic [XLEN-1:0]            wake_k_val [RS_DEPTH];
    logic [RS_WIDTH-1:0]        free_idx;
    logic [RS_WIDTH-1:0]        sel_idx;
    logic                       sel_valid;
    logic                       disp_acc;
    logic                       byp_sel;
    logic                       st_fire;
    logic                       wr_en;
    logic [XLEN:0]              cap_j;
    logic [XLEN:0]              cap_k;
    logic [XLEN-1:0]            vj_new;
    logic [XLEN-1:0]            vk_new;
    rs_ctl_t                    ctl_new;

    // Lowest matching valid CDB channel for a tag: {hit, value}
    function automatic logic [XLEN:0] cdb_match(input logic [ROB_WIDTH-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            if (!r[XLEN] && cdb_valid[c] && (cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == tag)) begin
                r = {1'b1, cdb_value[c*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    // Occupancy, readiness and lowest free slot from the busy bits
    always_comb begin
        busy     = '0;
        ready    = '0;
        rs_count = '0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            busy[i]  = ctl[i].busy;
            ready[i] = ctl[i].busy & ~ctl[i].dj & ~ctl[i].dk;
            rs_count = rs_count + CW'(ctl[i].busy);
        end
        for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = RS_WIDTH'(i);
            end
        end
        rs_full = &busy;
    end

    // Per-entry CDB snoop for waiting operands
    always_comb begin
        logic [XLEN:0] mj;
        logic [XLEN:0] mk;
        mj = '0;
        mk = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            mj            = cdb_match(qj[i]);
            mk            = cdb_match(qk[i]);
            wake_j[i]     = ctl[i].busy & ctl[i].dj & mj[XLEN];
            wake_k[i]     = ctl[i].busy & ctl[i].dk & mk[XLEN];
            wake_j_val[i] = mj[XLEN-1:0];
            wake_k_val[i] = mk[XLEN-1:0];
        end
    end

    rs_age_select #(
        .N  (RS_DEPTH),
        .IW (RS_WIDTH)
    ) u_select (
        .ready (ready),
        .older (older),
        .grant (grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Dispatch acceptance, dispatch-time capture and issue handshake decode
    always_comb begin
        cap_j    = cdb_match(dep_j);
        cap_k    = cdb_match(dep_k);
        vj_new   = (has_dep_j && cap_j[XLEN]) ? cap_j[XLEN-1:0] : val_j;
        vk_new   = (has_dep_k && cap_k[XLEN]) ? cap_k[XLEN-1:0] : val_k;
        ctl_new  = '{busy: 1'b1,
                     dj:   has_dep_j & ~cap_j[XLEN],
                     dk:   has_dep_k & ~cap_k[XLEN],
                     op:   dec_type,
                     tja:  tja,
                     fja:  fja};
        disp_acc = rdy_in & ~clear & dec_valid & ~rs_full;
`ifdef RS_ISSUE_BYPASS_EN
        byp_sel  = disp_acc & ~ctl_new.dj & ~ctl_new.dk & ~sel_valid;
`else
        byp_sel  = 1'b0;
`endif
        iss_valid = rdy_in & ~clear & (sel_valid | byp_sel);
        st_fire   = iss_valid & iss_ready & sel_valid;
        wr_en     = disp_acc & ~(byp_sel & iss_ready);
    end

    // Issue payload: stored oldest-ready entry, else the bypassed dispatch, else zero
    always_comb begin
        iss_op     = '0;
        iss_lhs    = '0;
        iss_rhs    = '0;
        iss_rob_id = '0;
        iss_tja    = '0;
        iss_fja    = '0;
        if (iss_valid && sel_valid) begin
            iss_op     = ctl[sel_idx].op;
            iss_lhs    = vj[sel_idx];
            iss_rhs    = vk[sel_idx];
            iss_rob_id = rob[sel_idx];
            iss_tja    = ctl[sel_idx].tja;
            iss_fja    = ctl[sel_idx].fja;
        end else if (iss_valid) begin
            iss_op     = dec_type;
            iss_lhs    = vj_new;
            iss_rhs    = vk_new;
            iss_rob_id = rob_id;
            iss_tja    = tja;
            iss_fja    = fja;
        end
    end

    // Entry storage and age matrix update: flush, wakeup, issue free, dispatch write
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                ctl[i] <= '0;
                vj[i]  <= '0;
                vk[i]  <= '0;
                qj[i]  <= '0;
                qk[i]  <= '0;
                rob[i] <= '0;
            end
            older <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    ctl[i].busy <= 1'b0;
                end
                older <= '0;
            end else begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    if (wake_j[i]) begin
                        vj[i]     <= wake_j_val[i];
                        ctl[i].dj <= 1'b0;
                    end
                    if (wake_k[i]) begin
                        vk[i]     <= wake_k_val[i];
                        ctl[i].dk <= 1'b0;
                    end
                    if (st_fire && grant[i]) begin
                        ctl[i].busy <= 1'b0;
                        for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                            older[j][i] <= 1'b0;
                        end
                    end
                end
                if (wr_en) begin
                    ctl[free_idx]   <= ctl_new;
                    vj[free_idx]    <= vj_new;
                    vk[free_idx]    <= vk_new;
                    qj[free_idx]    <= dep_j;
                    qk[free_idx]    <= dep_k;
                    rob[free_idx]   <= rob_id;
                    older[free_idx] <= '0;
                    // Every entry still resident after this edge is older than the new one
                    for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                        if (busy[j] && !(st_fire && grant[j])) begin
                            older[j][free_idx] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age.sv
// tb_rs_age: directed scenarios plus randomized traffic checked every cycle against an
// age-ordered queue model of the reservation station.
`timescale 1ns/1ps
module tb_rs_age;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned RW    = 3;
    localparam int unsigned ROBW  = 4;
    localparam int unsigned NCDB  = 2;
    localparam int unsigned XL    = 32;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic                   rdy_in;
    logic                   clear;
    logic                   dec_valid;
    logic [4:0]             dec_type;
    logic [XL-1:0]          val_j, val_k;
    logic                   has_dep_j, has_dep_k;
    logic [ROBW-1:0]        dep_j, dep_k, rob_id;
    logic [31:0]            tja, fja;
    logic                   rs_full;
    logic [RW:0]            rs_count;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*ROBW-1:0]   cdb_rob_id;
    logic [NCDB*XL-1:0]     cdb_value;
    logic                   iss_valid, iss_ready;
    logic [4:0]             iss_op;
    logic [XL-1:0]          iss_lhs, iss_rhs;
    logic [ROBW-1:0]        iss_rob_id;
    logic [31:0]            iss_tja, iss_fja;

    rs_age #(
        .RS_DEPTH (DEPTH), .RS_WIDTH (RW), .ROB_WIDTH (ROBW), .NUM_CDB (NCDB), .XLEN (XL)
    ) dut (
        .clk_in (clk_in), .rst_n_in (rst_n_in), .rdy_in (rdy_in), .clear (clear),
        .dec_valid (dec_valid), .dec_type (dec_type), .val_j (val_j), .val_k (val_k),
        .has_dep_j (has_dep_j), .has_dep_k (has_dep_k), .dep_j (dep_j), .dep_k (dep_k),
        .rob_id (rob_id), .tja (tja), .fja (fja), .rs_full (rs_full), .rs_count (rs_count),
        .cdb_valid (cdb_valid), .cdb_rob_id (cdb_rob_id), .cdb_value (cdb_value),
        .iss_valid (iss_valid), .iss_ready (iss_ready), .iss_op (iss_op),
        .iss_lhs (iss_lhs), .iss_rhs (iss_rhs), .iss_rob_id (iss_rob_id),
        .iss_tja (iss_tja), .iss_fja (iss_fja)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ROBW-1:0] rob;
        logic [4:0]      op;
        logic [XL-1:0]   vj, vk;
        bit              dj, dk;
        logic [ROBW-1:0] qj, qk;
        logic [31:0]     tja, fja;
    } ent_t;

    ent_t            mq[$];      // model entries, oldest first
    logic [ROBW-1:0] issued[$];  // tags the DUT handed over, for directed checks
    int              n_chk  = 0;
    int              n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit cdb_lookup(input logic [ROBW-1:0] tag, output logic [XL-1:0] v);
        v = '0;
        for (int c = 0; c < int'(NCDB); c++) begin
            if (cdb_valid[c] && cdb_rob_id[c*ROBW +: ROBW] == tag) begin
                v = cdb_value[c*XL +: XL];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Per-cycle check of DUT outputs against the model, then advance the model across the edge
    always @(negedge clk_in) begin : cmp
        int            oi;
        bit            acc, byp, ev, fire;
        ent_t          ne, o;
        logic [XL-1:0] cv;
        if (!rst_n_in) begin
            mq.delete();
            chk("rst_count", 64'(rs_count), 64'd0);
            chk("rst_valid", 64'(iss_valid), 64'd0);
        end else begin
            oi = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (oi < 0 && !mq[i].dj && !mq[i].dk) oi = i;
            end
            acc   = rdy_in && !clear && dec_valid && (mq.size() < int'(DEPTH));
            ne.rob = rob_id; ne.op = dec_type; ne.tja = tja; ne.fja = fja;
            ne.dj = has_dep_j; ne.vj = val_j; ne.qj = dep_j;
            ne.dk = has_dep_k; ne.vk = val_k; ne.qk = dep_k;
            if (has_dep_j && cdb_lookup(dep_j, cv)) begin ne.dj = 1'b0; ne.vj = cv; end
            if (has_dep_k && cdb_lookup(dep_k, cv)) begin ne.dk = 1'b0; ne.vk = cv; end
            byp = 1'b0;
`ifdef RS_ISSUE_BYPASS_EN
            byp = acc && (oi < 0) && !ne.dj && !ne.dk;
`endif
            ev = rdy_in && !clear && ((oi >= 0) || byp);
            chk("rs_count", 64'(rs_count), 64'(mq.size()));
            chk("rs_full", 64'(rs_full), 64'(mq.size() == int'(DEPTH)));
            chk("iss_valid", 64'(iss_valid), 64'(ev));
            if (ev) begin
                o = (oi >= 0) ? mq[oi] : ne;
                chk("iss_op", 64'(iss_op), 64'(o.op));
                chk("iss_lhs", 64'(iss_lhs), 64'(o.vj));
                chk("iss_rhs", 64'(iss_rhs), 64'(o.vk));
                chk("iss_rob_id", 64'(iss_rob_id), 64'(o.rob));
                chk("iss_tja", 64'(iss_tja), 64'(o.tja));
                chk("iss_fja", 64'(iss_fja), 64'(o.fja));
            end
            if (iss_valid && iss_ready) issued.push_back(iss_rob_id);
            if (rdy_in) begin
                if (clear) begin
                    mq.delete();
                end else begin
                    foreach (mq[i]) begin
                        if (mq[i].dj && cdb_lookup(mq[i].qj, cv)) begin mq[i].dj = 1'b0; mq[i].vj = cv; end
                        if (mq[i].dk && cdb_lookup(mq[i].qk, cv)) begin mq[i].dk = 1'b0; mq[i].vk = cv; end
                    end
                    fire = ev && iss_ready;
                    if (fire && oi >= 0) mq.delete(oi);
                    if (acc && !(fire && byp)) mq.push_back(ne);
                end
            end
        end
    end

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0; dec_valid = 1'b0; dec_type = '0;
        val_j = '0; val_k = '0; has_dep_j = 1'b0; has_dep_k = 1'b0;
        dep_j = '0; dep_k = '0; rob_id = '0; tja = '0; fja = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0; iss_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [ROBW-1:0] r, input bit hj, input logic [ROBW-1:0] tj,
                        input bit hk, input logic [ROBW-1:0] tk, input logic [XL-1:0] a,
                        input logic [XL-1:0] b);
        dec_valid = 1'b1; rob_id = r; dec_type = 5'(r) ^ 5'h10;
        has_dep_j = hj; dep_j = tj; has_dep_k = hk; dep_k = tk;
        val_j = a; val_k = b; tja = 32'h1000 + 32'(r); fja = 32'h2000 + 32'(r);
    endtask

    task automatic bcast(input int c, input logic [ROBW-1:0] tag, input logic [XL-1:0] v);
        cdb_valid[c] = 1'b1;
        cdb_rob_id[c*ROBW +: ROBW] = tag;
        cdb_value[c*XL +: XL] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_in = 1'b0;
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_count", 64'(rs_count), 64'd0);
        chk("reset_full", 64'(rs_full), 64'd0);
        chk("reset_valid", 64'(iss_valid), 64'd0);
        chk("reset_lhs", 64'(iss_lhs), 64'd0);
        chk("reset_rob", 64'(iss_rob_id), 64'd0);
        rst_n_in = 1'b1;

        // Three independent entries issue oldest-first back to back
        for (int r = 1; r <= 3; r++) begin
            idle(); disp(4'(r), 0, 0, 0, 0, 32'h100 + 32'(r), 32'h200 + 32'(r)); step();
        end
        idle(); #1;
        chk("t1_count3", 64'(rs_count), 64'd3);
        chk("t1_offer_rob1", 64'(iss_rob_id), 64'd1);
        issued.delete();
        iss_ready = 1'b1;
        repeat (3) step();
        idle(); #1;
        chk("t1_count0", 64'(rs_count), 64'd0);
        chk("t1_n_issued", 64'(issued.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk("t1_order", 64'(issued[k]), 64'(k + 1));

        // Fill with entries waiting on tag 5, overflow dispatch ignored, one CDB wakes all
        issued.delete();
        for (int r = 8; r < 16; r++) begin
            idle(); disp(4'(r), 1, 4'd5, 0, 0, 0, 32'(r)); iss_ready = 1'b1; step();
        end
        idle(); #1;
        chk("t2_full", 64'(rs_full), 64'd1);
        chk("t2_count8", 64'(rs_count), 64'd8);
        chk("t2_model_size", 64'(mq.size()), 64'd8);
        idle(); disp(4'd0, 0, 0, 0, 0, 32'h9, 32'h9); step();
        idle(); #1;
        chk("t2_ignored_count", 64'(rs_count), 64'd8);
        chk("t2_not_ready", 64'(iss_valid), 64'd0);
        idle(); bcast(1, 4'd5, 32'h1234); step();
        idle(); #1;
        chk("t2_woken_valid", 64'(iss_valid), 64'd1);
        chk("t2_woken_lhs", 64'(iss_lhs), 64'h1234);
        chk("t2_oldest_rob", 64'(iss_rob_id), 64'd8);
        iss_ready = 1'b1;
        repeat (8) step();
        idle(); #1;
        chk("t2_drained", 64'(rs_count), 64'd0);
        for (int k = 0; k < 8; k++) chk("t2_order", 64'(issued[k]), 64'(k + 8));

        // Dispatch-time capture from CDB channel 0
        idle(); disp(4'd7, 1, 4'd3, 0, 0, 0, 32'h77); bcast(0, 4'd3, 32'hAA); step();
        idle(); #1;
        chk("t3_valid", 64'(iss_valid), 64'd1);
        chk("t3_lhs", 64'(iss_lhs), 64'hAA);
        chk("t3_rob", 64'(iss_rob_id), 64'd7);
        iss_ready = 1'b1; step(); idle();

        // Both operands woken by different channels in one cycle
        idle(); disp(4'd9, 1, 4'd2, 1, 4'd4, 0, 0); step();
        idle(); #1;
        chk("t4_waiting", 64'(iss_valid), 64'd0);
        idle(); bcast(0, 4'd2, 32'h10); bcast(1, 4'd4, 32'h20); step();
        idle(); #1;
        chk("t4_lhs", 64'(iss_lhs), 64'h10);
        chk("t4_rhs", 64'(iss_rhs), 64'h20);
        iss_ready = 1'b1; step(); idle();

        // Stalled offer stays put, then flush, then async reset mid-stream
        idle(); disp(4'd11, 0, 0, 0, 0, 32'h5555, 32'h6666); step();
        for (int k = 0; k < 3; k++) begin
            idle(); #1;
            chk("t5_hold_valid", 64'(iss_valid), 64'd1);
            chk("t5_hold_rob", 64'(iss_rob_id), 64'd11);
            chk("t5_hold_lhs", 64'(iss_lhs), 64'h5555);
            step();
        end
        idle(); clear = 1'b1; #1;
        chk("t5_clear_valid", 64'(iss_valid), 64'd0);
        step();
        idle(); #1;
        chk("t5_flushed_count", 64'(rs_count), 64'd0);
        chk("t5_flushed_valid", 64'(iss_valid), 64'd0);
        idle(); disp(4'd12, 0, 0, 0, 0, 1, 2); step();
        idle(); disp(4'd13, 1, 4'd1, 0, 0, 3, 4); step();
        idle(); #1;
        chk("t5_count2", 64'(rs_count), 64'd2);
        rst_n_in = 1'b0; #1;
        chk("t5_rst_count", 64'(rs_count), 64'd0);
        chk("t5_rst_valid", 64'(iss_valid), 64'd0);
        chk("t5_rst_lhs", 64'(iss_lhs), 64'd0);
        step();
        rst_n_in = 1'b1;
        idle();

`ifdef RS_ISSUE_BYPASS_EN
        // Resolved dispatch into an idle station goes straight to the ALU
        issued.delete();
        idle(); disp(4'd6, 0, 0, 0, 0, 32'h66, 32'h67); iss_ready = 1'b1; #1;
        chk("t6_byp_valid", 64'(iss_valid), 64'd1);
        chk("t6_byp_rob", 64'(iss_rob_id), 64'd6);
        chk("t6_byp_lhs", 64'(iss_lhs), 64'h66);
        step();
        idle(); #1;
        chk("t6_byp_count", 64'(rs_count), 64'd0);
        chk("t6_byp_issued", 64'(issued.size()), 64'd1);
        chk("t6_byp_tag", 64'(issued[0]), 64'd6);
`endif

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            rdy_in    = ($urandom_range(0, 15) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            iss_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                disp(4'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
                     1'($urandom), 4'($urandom_range(0, 7)), $urandom, $urandom);
                dec_type = 5'($urandom);
                tja = $urandom;
                fja = $urandom;
            end
            for (int c = 0; c < int'(NCDB); c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [ROBW-1:0] tg;
                    logic [XL-1:0]   vv;
                    tg = 4'($urandom_range(0, 7));
                    vv = $urandom;
                    for (int p = 0; p < c; p++) begin
                        if (cdb_valid[p] && cdb_rob_id[p*ROBW +: ROBW] == tg) vv = cdb_value[p*XL +: XL];
                    end
                    bcast(c, tg, vv);
                end
            end
            step();
        end

        idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
